// File: rtl/chrono_multi_timer.sv
// chrono_multi_timer: 24 h clock with field edit and N_TMR mm:ss countdown timers.
// Define ALARM_EN to add the ALARM_SET mode and the alarm output.
module chrono_multi_timer #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int DEB_CYCLES = 15_000_000,
  parameter int N_TMR      = 2,
  parameter int TMR_MAXMIN = 99
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             btn_mode,
  input  logic             btn_shift,
  input  logic             btn_inc,
  input  logic             btn_ss,
  input  logic             btn_clr,
  output logic [4:0]       hours,
  output logic [6:0]       minutes,
  output logic [5:0]       seconds,
  output logic [2:0]       mode_led,
  output logic             edit_field,
  output logic [2:0]       tmr_sel,
  output logic [N_TMR-1:0] tmr_run,
  output logic [N_TMR-1:0] tmr_done,
  output logic             sec_tick,
  output logic             alarm
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int B_SS = 0, B_INC = 1, B_SHIFT = 2, B_MODE = 3, B_CLR = 4;

  typedef enum logic [1:0] {
    M_CLOCK = 2'd0,
    M_EDIT  = 2'd1,
    M_TIMER = 2'd2,
    M_ALARM = 2'd3
  } mode_t;

  logic [PW-1:0]    presc_q, presc_d;
  logic             sec_tick_q, sec_tick_d;
  logic [4:0]       btn_raw, lock_q, lock_d, fire, act;
  logic [DW-1:0]    hold_q [5];
  logic [DW-1:0]    hold_d [5];
  mode_t            mode_q, mode_d;
  logic             field_q, field_d;
  logic [2:0]       sel_q, sel_d;
  logic [4:0]       hh_q, hh_d;
  logic [5:0]       mm_q, mm_d, ss_q, ss_d;
  logic [6:0]       t_mm_q [N_TMR];
  logic [6:0]       t_mm_d [N_TMR];
  logic [5:0]       t_ss_q [N_TMR];
  logic [5:0]       t_ss_d [N_TMR];
  logic [N_TMR-1:0] run_q, run_d, done_q, done_d;
  logic [4:0]       hours_q, hours_d;
  logic [6:0]       minutes_q, minutes_d;
  logic [5:0]       seconds_q, seconds_d;
  logic [2:0]       led_q, led_d;
  logic             tick, edit_hit;

`ifdef ALARM_EN
  logic [4:0]       al_hh_q, al_hh_d;
  logic [5:0]       al_mm_q, al_mm_d;
  logic             armed_q, armed_d, ring_q, ring_d, clk_adv;
  logic [5:0]       ring_cnt_q, ring_cnt_d;
`endif

  assign btn_raw = {btn_clr, btn_mode, btn_shift, btn_inc, btn_ss};
  assign tick    = sec_tick_q;

  always_comb begin
    presc_d    = (presc_q == PW'(CLK_HZ - 1)) ? '0 : presc_q + 1'b1;
    sec_tick_d = (presc_d == PW'(CLK_HZ - 1));
  end

  // A button held through reset stays locked until it is released.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      lock_d[i] = lock_q[i] & btn_raw[i];
      hold_d[i] = '0;
      fire[i]   = 1'b0;
      if (btn_raw[i] && !lock_q[i]) begin
        fire[i]   = (hold_q[i] == DW'(DEB_CYCLES - 1));
        hold_d[i] = (hold_q[i] == DW'(DEB_CYCLES)) ? hold_q[i] : hold_q[i] + 1'b1;
      end
    end
    act = '0;
    if (fire[B_CLR])        act[B_CLR]   = 1'b1;
    else if (fire[B_MODE])  act[B_MODE]  = 1'b1;
    else if (fire[B_SHIFT]) act[B_SHIFT] = 1'b1;
    else if (fire[B_INC])   act[B_INC]   = 1'b1;
    else if (fire[B_SS])    act[B_SS]    = 1'b1;
  end

  always_comb begin
    mode_d  = mode_q;
    field_d = field_q;
    sel_d   = sel_q;
    if (act[B_MODE]) begin
      field_d = 1'b1;
      case (mode_q)
        M_CLOCK: mode_d = M_EDIT;
        M_EDIT:  mode_d = M_TIMER;
`ifdef ALARM_EN
        M_TIMER: mode_d = M_ALARM;
`endif
        default: mode_d = M_CLOCK;
      endcase
    end else if (act[B_SHIFT]) begin
      case (mode_q)
        M_EDIT, M_ALARM: field_d = ~field_q;
        M_TIMER: begin
          if (field_q) begin
            field_d = 1'b0;
          end else begin
            field_d = 1'b1;
            sel_d   = (sel_q == 3'(N_TMR - 1)) ? 3'd0 : sel_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Edits in EDIT mode take precedence over a coincident second tick.
  always_comb begin
    hh_d     = hh_q;
    mm_d     = mm_q;
    ss_d     = ss_q;
    edit_hit = (mode_q == M_EDIT) && (act[B_INC] || act[B_CLR]);
    if (mode_q == M_EDIT && act[B_CLR]) begin
      hh_d = '0;
      mm_d = '0;
      ss_d = '0;
    end else if (mode_q == M_EDIT && act[B_INC]) begin
      ss_d = '0;
      if (field_q) hh_d = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
      else         mm_d = (mm_q == 6'd59) ? 6'd0 : mm_q + 6'd1;
    end else if (tick) begin
      if (ss_q == 6'd59) begin
        ss_d = '0;
        if (mm_q == 6'd59) begin
          mm_d = '0;
          hh_d = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
        end else begin
          mm_d = mm_q + 6'd1;
        end
      end else begin
        ss_d = ss_q + 6'd1;
      end
    end
  end

  // Button actions on the selected channel win over a coincident tick.
  always_comb begin
    for (int i = 0; i < N_TMR; i++) begin
      t_mm_d[i] = t_mm_q[i];
      t_ss_d[i] = t_ss_q[i];
      run_d[i]  = run_q[i];
      done_d[i] = 1'b0;
      if (mode_q == M_TIMER && sel_q == 3'(i) && act[B_CLR]) begin
        t_mm_d[i] = '0;
        t_ss_d[i] = '0;
        run_d[i]  = 1'b0;
      end else if (mode_q == M_TIMER && sel_q == 3'(i) && act[B_SS]) begin
        if (run_q[i])                             run_d[i] = 1'b0;
        else if (t_mm_q[i] != '0 || t_ss_q[i] != '0) run_d[i] = 1'b1;
      end else if (mode_q == M_TIMER && sel_q == 3'(i) && act[B_INC] && !run_q[i]) begin
        if (field_q) t_mm_d[i] = (t_mm_q[i] == 7'(TMR_MAXMIN)) ? 7'd0 : t_mm_q[i] + 7'd1;
        else         t_ss_d[i] = (t_ss_q[i] == 6'd59) ? 6'd0 : t_ss_q[i] + 6'd1;
      end else if (tick && run_q[i]) begin
        if (t_ss_q[i] == '0) begin
          t_mm_d[i] = t_mm_q[i] - 7'd1;
          t_ss_d[i] = 6'd59;
        end else begin
          t_ss_d[i] = t_ss_q[i] - 6'd1;
        end
        if (t_mm_q[i] == '0 && t_ss_q[i] == 6'd1) begin
          run_d[i]  = 1'b0;
          done_d[i] = 1'b1;
        end
      end
    end
  end

`ifdef ALARM_EN
  always_comb begin
    al_hh_d    = al_hh_q;
    al_mm_d    = al_mm_q;
    armed_d    = armed_q;
    ring_d     = ring_q;
    ring_cnt_d = ring_cnt_q;
    clk_adv    = tick && !edit_hit;
    if (mode_q == M_ALARM) begin
      if (act[B_CLR])     armed_d = 1'b0;
      else if (act[B_SS]) armed_d = ~armed_q;
      else if (act[B_INC]) begin
        if (field_q) al_hh_d = (al_hh_q == 5'd23) ? 5'd0 : al_hh_q + 5'd1;
        else         al_mm_d = (al_mm_q == 6'd59) ? 6'd0 : al_mm_q + 6'd1;
      end
    end
    if (ring_q) begin
      if (|act) ring_d = 1'b0;
      else if (tick) begin
        if (ring_cnt_q == 6'd59) ring_d = 1'b0;
        else                     ring_cnt_d = ring_cnt_q + 6'd1;
      end
    end else if (armed_q && clk_adv && hh_d == al_hh_q && mm_d == al_mm_q && ss_d == '0) begin
      ring_d     = 1'b1;
      ring_cnt_d = '0;
    end
  end
`endif

  // Display follows next state so the registered outputs line up with the state flops.
  always_comb begin
    hours_d   = hh_d;
    minutes_d = {1'b0, mm_d};
    seconds_d = ss_d;
    led_d     = 3'b100;
    case (mode_d)
      M_EDIT: led_d = 3'b010;
      M_TIMER: begin
        led_d     = 3'b001;
        hours_d   = {2'b00, sel_d};
        minutes_d = '0;
        seconds_d = '0;
        for (int i = 0; i < N_TMR; i++) begin
          if (sel_d == 3'(i)) begin
            minutes_d = t_mm_d[i];
            seconds_d = t_ss_d[i];
          end
        end
      end
`ifdef ALARM_EN
      M_ALARM: begin
        led_d     = 3'b111;
        hours_d   = al_hh_d;
        minutes_d = {1'b0, al_mm_d};
        seconds_d = '0;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q    <= '0;
      sec_tick_q <= 1'b0;
      lock_q     <= '1;
      for (int i = 0; i < 5; i++) hold_q[i] <= '0;
      mode_q     <= M_CLOCK;
      field_q    <= 1'b1;
      sel_q      <= '0;
      hh_q       <= '0;
      mm_q       <= '0;
      ss_q       <= '0;
      for (int i = 0; i < N_TMR; i++) begin
        t_mm_q[i] <= '0;
        t_ss_q[i] <= '0;
      end
      run_q      <= '0;
      done_q     <= '0;
      hours_q    <= '0;
      minutes_q  <= '0;
      seconds_q  <= '0;
      led_q      <= 3'b100;
`ifdef ALARM_EN
      al_hh_q    <= '0;
      al_mm_q    <= '0;
      armed_q    <= 1'b0;
      ring_q     <= 1'b0;
      ring_cnt_q <= '0;
`endif
    end else begin
      presc_q    <= presc_d;
      sec_tick_q <= sec_tick_d;
      lock_q     <= lock_d;
      for (int i = 0; i < 5; i++) hold_q[i] <= hold_d[i];
      mode_q     <= mode_d;
      field_q    <= field_d;
      sel_q      <= sel_d;
      hh_q       <= hh_d;
      mm_q       <= mm_d;
      ss_q       <= ss_d;
      for (int i = 0; i < N_TMR; i++) begin
        t_mm_q[i] <= t_mm_d[i];
        t_ss_q[i] <= t_ss_d[i];
      end
      run_q      <= run_d;
      done_q     <= done_d;
      hours_q    <= hours_d;
      minutes_q  <= minutes_d;
      seconds_q  <= seconds_d;
      led_q      <= led_d;
`ifdef ALARM_EN
      al_hh_q    <= al_hh_d;
      al_mm_q    <= al_mm_d;
      armed_q    <= armed_d;
      ring_q     <= ring_d;
      ring_cnt_q <= ring_cnt_d;
`endif
    end
  end

  assign hours      = hours_q;
  assign minutes    = minutes_q;
  assign seconds    = seconds_q;
  assign mode_led   = led_q;
  assign edit_field = field_q;
  assign tmr_sel    = sel_q;
  assign tmr_run    = run_q;
  assign tmr_done   = done_q;
  assign sec_tick   = sec_tick_q;
`ifdef ALARM_EN
  assign alarm      = ring_q;
`else
  assign alarm      = 1'b0;
`endif

endmodule

// File: tb/tb_chrono_multi_timer.sv
// Scoreboard bench for chrono_multi_timer: directed presses push expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_chrono_multi_timer;

  localparam int CLK_HZ = 10, DEB = 3, NT = 2, MAXMIN = 99;
  localparam int B_SS = 0, B_INC = 1, B_SHIFT = 2, B_MODE = 3, B_CLR = 4;
  localparam int S_HR = 0, S_MIN = 1, S_SEC = 2, S_LED = 3, S_FLD = 4,
                 S_SEL = 5, S_RUN = 6, S_DONE = 7, S_TICK = 8, S_ALM = 9;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [4:0]    btn = '0;
  logic [4:0]    hours;
  logic [6:0]    minutes;
  logic [5:0]    seconds;
  logic [2:0]    mode_led;
  logic          edit_field;
  logic [2:0]    tmr_sel;
  logic [NT-1:0] tmr_run;
  logic [NT-1:0] tmr_done;
  logic          sec_tick;
  logic          alarm;

  chrono_multi_timer #(.CLK_HZ(CLK_HZ), .DEB_CYCLES(DEB), .N_TMR(NT), .TMR_MAXMIN(MAXMIN)) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_mode(btn[B_MODE]), .btn_shift(btn[B_SHIFT]), .btn_inc(btn[B_INC]),
    .btn_ss(btn[B_SS]), .btn_clr(btn[B_CLR]),
    .hours(hours), .minutes(minutes), .seconds(seconds), .mode_led(mode_led),
    .edit_field(edit_field), .tmr_sel(tmr_sel), .tmr_run(tmr_run),
    .tmr_done(tmr_done), .sec_tick(sec_tick), .alarm(alarm)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    sel;
    int    val;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   tick_cnt = 0;
  int   t0, t1, ta;

  function automatic int pick(int sel);
    case (sel)
      S_HR:    return int'(hours);
      S_MIN:   return int'(minutes);
      S_SEC:   return int'(seconds);
      S_LED:   return int'(mode_led);
      S_FLD:   return int'(edit_field);
      S_SEL:   return int'(tmr_sel);
      S_RUN:   return int'(tmr_run);
      S_DONE:  return int'(tmr_done);
      S_TICK:  return int'(sec_tick);
      S_ALM:   return int'(alarm);
      default: return -1;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (sec_tick) tick_cnt++;
    while (expq.size() > 0) begin
      e = expq.pop_front();
      a = pick(e.sel);
      n_checks++;
      if (a != e.val) begin
        n_fail++;
        $display("FAIL %s: got %0d, expected %0d", e.name, a, e.val);
      end
    end
  end

  task automatic chk(input string nm, input int sel, input int v);
    exp_t e;
    e.name = nm;
    e.sel  = sel;
    e.val  = v;
    expq.push_back(e);
  endtask

  task automatic cmp(input string nm, input int a, input int v);
    n_checks++;
    if (a != v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, a, v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int b, input int hold = 3);
    cyc(1);
    btn[b] = 1'b1;
    cyc(hold);
    btn[b] = 1'b0;
  endtask

  task automatic press_n(input int b, input int n);
    repeat (n) press(b);
  endtask

  task automatic wait_tick();
    bit got;
    int k;
    got = 1'b0;
    k = 0;
    while (!got && k < 30) begin
      @(negedge clk);
      got = sec_tick;
      k++;
    end
    @(posedge clk);
    #1;
    if (!got) cmp("tick_timeout", 0, 1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc(3);
    chk("rst_hours", S_HR, 0);
    chk("rst_minutes", S_MIN, 0);
    chk("rst_seconds", S_SEC, 0);
    chk("rst_mode_led", S_LED, 4);
    chk("rst_edit_field", S_FLD, 1);
    chk("rst_tmr_sel", S_SEL, 0);
    chk("rst_tmr_run", S_RUN, 0);
    chk("rst_tmr_done", S_DONE, 0);
    chk("rst_sec_tick", S_TICK, 0);
    chk("rst_alarm", S_ALM, 0);
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int k;
    cyc(1);
    do_reset();
    ta = tick_cnt;

    // 600 seconds of free running, then roll over from 23:59:59
    repeat (600) wait_tick();
    cmp("ticks_600", tick_cnt - ta, 600);
    chk("t600_hours", S_HR, 0);
    chk("t600_minutes", S_MIN, 10);
    chk("t600_seconds", S_SEC, 0);
    chk("t600_led", S_LED, 4);
    press(B_MODE);
    chk("edit_led", S_LED, 2);
    chk("edit_field_hi", S_FLD, 1);
    press(B_CLR);
    chk("clr_hours", S_HR, 0);
    chk("clr_minutes", S_MIN, 0);
    chk("clr_seconds", S_SEC, 0);
    press_n(B_INC, 23);
    chk("set_hh23", S_HR, 23);
    chk("set_hh23_mm", S_MIN, 0);
    chk("set_hh23_ss", S_SEC, 0);
    press(B_SHIFT);
    chk("edit_field_lo", S_FLD, 0);
    press_n(B_INC, 59);
    chk("set_mm59_hh", S_HR, 23);
    chk("set_mm59", S_MIN, 59);
    chk("set_mm59_ss", S_SEC, 0);
    repeat (59) wait_tick();
    chk("pre_roll_hh", S_HR, 23);
    chk("pre_roll_mm", S_MIN, 59);
    chk("pre_roll_ss", S_SEC, 59);
    wait_tick();
    chk("roll_hh", S_HR, 0);
    chk("roll_mm", S_MIN, 0);
    chk("roll_ss", S_SEC, 0);

    // hold qualification and hh wrap
    press(B_SHIFT);
    chk("field_back_hi", S_FLD, 1);
    cyc(1);
    btn[B_INC] = 1'b1;
    cyc(2);
    btn[B_INC] = 1'b0;
    cyc(2);
    chk("short_hold_hours", S_HR, 0);
    press(B_INC, 10);
    chk("long_hold_hours", S_HR, 1);
    chk("long_hold_minutes", S_MIN, 0);
    press_n(B_INC, 22);
    chk("hh_at_23", S_HR, 23);
    press(B_INC);
    chk("hh_wrap", S_HR, 0);
    chk("hh_wrap_ss", S_SEC, 0);

    // timers: ch0 = 00:02, ch1 = 01:00
    press(B_MODE);
    chk("timer_led", S_LED, 1);
    chk("timer_sel0", S_HR, 0);
    chk("timer_field", S_FLD, 1);
    press(B_SHIFT);
    press_n(B_INC, 2);
    chk("ch0_ss", S_SEC, 2);
    chk("ch0_mm", S_MIN, 0);
    press(B_SHIFT);
    chk("sel_ch1", S_HR, 1);
    chk("sel_ch1_field", S_FLD, 1);
    press(B_INC);
    chk("ch1_mm", S_MIN, 1);
    chk("ch1_ss", S_SEC, 0);
    press(B_SS);
    t1 = tick_cnt;
    chk("run_ch1", S_RUN, 2);
    press_n(B_SHIFT, 2);
    chk("sel_wrap", S_SEL, 0);
    press(B_SS);
    t0 = tick_cnt;
    chk("run_both", S_RUN, 3);
    press(B_MODE);
    chk("back_clock_led", S_LED, 4);
    got = 1'b0;
    k = 0;
    while (!got && k < 60) begin
      @(negedge clk);
      got = tmr_done[0];
      k++;
    end
    if (!got) cmp("done0_timeout", 0, 1);
    cyc(1);
    cmp("ch0_ticks_to_done", tick_cnt - t0, 2);
    chk("done0_width", S_DONE, 0);
    chk("run_after_done", S_RUN, 2);
    press_n(B_MODE, 2);
    press_n(B_SHIFT, 2);
    chk("view_ch1_sel", S_HR, 1);
    chk("ch1_mm_running", S_MIN, 0);
    chk("ch1_ss_running", S_SEC, 60 - (tick_cnt - t1));

    // inc ignored while running, clr stops, start at 00:00 ignored
    press(B_INC);
    chk("inc_running_mm", S_MIN, 0);
    chk("inc_running_ss", S_SEC, 60 - (tick_cnt - t1));
    press(B_CLR);
    chk("clr_run", S_RUN, 0);
    chk("clr_mm", S_MIN, 0);
    chk("clr_ss", S_SEC, 0);
    press(B_SS);
    chk("start_zero_run", S_RUN, 0);

    // priority: mode beats inc
    cyc(1);
    btn[B_MODE] = 1'b1;
    btn[B_INC]  = 1'b1;
    cyc(3);
    btn = '0;
`ifdef ALARM_EN
    chk("prio_led", S_LED, 7);
    press_n(B_MODE, 3);
`else
    chk("prio_led", S_LED, 4);
    press_n(B_MODE, 2);
`endif
    chk("prio_back_timer", S_LED, 1);
    chk("prio_sel", S_HR, 1);
    chk("prio_inc_ignored", S_MIN, 0);

    // buttons held through reset must be released first
    btn[B_MODE] = 1'b1;
    btn[B_INC]  = 1'b1;
    cyc(1);
    do_reset();
    cyc(10);
    chk("held_reset_led", S_LED, 4);
    chk("held_reset_field", S_FLD, 1);
    btn = '0;
    press(B_MODE);
    chk("after_release_led", S_LED, 2);

    // mode cycle
    press(B_MODE);
    chk("cycle_timer", S_LED, 1);
`ifdef ALARM_EN
    press(B_MODE);
    chk("cycle_alarm", S_LED, 7);
`endif
    press(B_MODE);
    chk("cycle_clock", S_LED, 4);

`ifdef ALARM_EN
    do_reset();
    ta = tick_cnt;
    press_n(B_MODE, 3);
    chk("al_led", S_LED, 7);
    chk("al_disp_hh", S_HR, 0);
    chk("al_disp_mm", S_MIN, 0);
    press(B_SHIFT);
    press(B_INC);
    chk("al_set_mm", S_MIN, 1);
    chk("al_disp_ss", S_SEC, 0);
    press(B_SS);
    press(B_MODE);
    k = 0;
    while (tick_cnt - ta < 59 && k < 100) begin
      wait_tick();
      k++;
    end
    chk("al_pre_ss", S_SEC, 59);
    chk("al_pre_alarm", S_ALM, 0);
    wait_tick();
    chk("al_ring_mm", S_MIN, 1);
    chk("al_ring_ss", S_SEC, 0);
    chk("al_ring", S_ALM, 1);
    press(B_INC);
    chk("al_cleared", S_ALM, 0);
`else
    chk("alarm_tied_low", S_ALM, 0);
`endif

    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
